instr_feeder: RTL and testbench

Upstream program buffer for the hidden CPU core. It takes a short program over a valid/ready load port and stores it in a 16-entry × 6-bit buffer. It then replays the program, one instruction per clock, onto the core's instruction pins (io_in[7:2]), and drives the core's synchronous reset. While a program is being loaded, the core is held in reset. The core is released once replay begins, so a bench or top-level can run a program without hand-driving pins each cycle.

---
 rtl/instr_feeder.sv | 147 ++++++++++++++
 tb/tb_instr_feeder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_feeder.sv
// Program buffer and replay engine for the core's instruction pins.
// A program is loaded over a valid/ready port and then replayed one word per clock, with the core's reset handled here.
module instr_feeder #(
   parameter int unsigned   DEPTH     = 16,
   parameter int unsigned   AW        = 4,
   parameter int unsigned   IW        = 6,
   parameter logic [IW-1:0] IDLE_WORD = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_start,
   input  logic          wr_valid,
   input  logic [IW-1:0] wr_data,
   input  logic          wr_last,
   output logic          wr_ready,
   input  logic          run_start,
   input  logic          loop_en,
   input  logic          stall,
   output logic [IW-1:0] instr_out,
   output logic          instr_valid,
   output logic          cpu_rst,
   output logic          done,
   output logic [AW:0]   prog_len,
   output logic [7:0]    issue_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t        r_state;
   logic [IW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_prog_len;
   logic [7:0]    r_issue_count;
   logic [IW-1:0] r_instr_out;
   logic          r_instr_valid;
   logic          r_cpu_rst;
   logic          r_wr_ready;
   logic          r_done;

   logic w_wr_fire;
   logic w_wr_full;
   logic w_rd_last;
   logic w_have_prog;

   assign w_wr_fire   = (r_state == S_LOAD) && wr_valid && r_wr_ready;
   assign w_wr_full   = (r_prog_len == (AW+1)'(DEPTH - 1));
   assign w_rd_last   = ({1'b0, r_rd_ptr} == (r_prog_len - (AW+1)'(1)));
   assign w_have_prog = (r_prog_len != '0);

   // Buffer storage carries no reset.
   always_ff @(posedge clk) begin
      if (!rst && w_wr_fire) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_prog_len    <= '0;
         r_issue_count <= '0;
         r_instr_out   <= IDLE_WORD;
         r_instr_valid <= 1'b0;
         r_cpu_rst     <= 1'b1;
         r_wr_ready    <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_HALT: begin
               r_instr_out   <= IDLE_WORD;
               r_instr_valid <= 1'b0;
               r_wr_ready    <= 1'b0;
               r_done        <= (r_state == S_HALT);
               // HALT keeps the core out of reset so its outputs stay observable.
               r_cpu_rst     <= (r_state == S_IDLE);
               if (load_start) begin
                  r_state    <= S_LOAD;
                  r_wr_ptr   <= '0;
                  r_prog_len <= '0;
                  r_wr_ready <= 1'b1;
                  r_cpu_rst  <= 1'b1;
                  r_done     <= 1'b0;
               end else if (run_start && w_have_prog) begin
                  r_state       <= S_RUN;
                  r_rd_ptr      <= '0;
                  r_issue_count <= '0;
                  r_cpu_rst     <= 1'b0;
                  r_done        <= 1'b0;
               end
            end
            S_LOAD: begin
               r_cpu_rst <= 1'b1;
               if (w_wr_fire) begin
                  r_wr_ptr   <= r_wr_ptr + AW'(1);
                  r_prog_len <= r_prog_len + (AW+1)'(1);
                  if (wr_last || w_wr_full) begin
                     r_state    <= S_IDLE;
                     r_wr_ready <= 1'b0;
                  end
               end
            end
            S_RUN: begin
               r_cpu_rst  <= 1'b0;
               r_done     <= 1'b0;
               r_wr_ready <= 1'b0;
               if (stall) begin
                  r_instr_out   <= IDLE_WORD;
                  r_instr_valid <= 1'b0;
               end else begin
                  r_instr_out   <= r_mem[r_rd_ptr];
                  r_instr_valid <= 1'b1;
                  if (r_issue_count != 8'hFF) begin
                     r_issue_count <= r_issue_count + 8'd1;
                  end
                  // Wrap on program length, not buffer depth.
                  if (w_rd_last) begin
                     r_rd_ptr <= '0;
                     if (!loop_en) begin
                        r_state <= S_HALT;
                     end
                  end else begin
                     r_rd_ptr <= r_rd_ptr + AW'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign wr_ready    = r_wr_ready;
   assign instr_out   = r_instr_out;
   assign instr_valid = r_instr_valid;
   assign cpu_rst     = r_cpu_rst;
   assign done        = r_done;
   assign prog_len    = r_prog_len;
   assign issue_count = r_issue_count;

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: directed and randomized loads/runs checked against a queue-based program model.
module tb_instr_feeder;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned IW    = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_start;
   logic          wr_valid;
   logic [IW-1:0] wr_data;
   logic          wr_last;
   logic          wr_ready;
   logic          run_start;
   logic          loop_en;
   logic          stall;
   logic [IW-1:0] instr_out;
   logic          instr_valid;
   logic          cpu_rst;
   logic          done;
   logic [AW:0]   prog_len;
   logic [7:0]    issue_count;

   int errors = 0;
   int checks = 0;

   logic [IW-1:0] prog[$];
   logic [IW-1:0] ld_words[$];

   instr_feeder dut (
      .clk         (clk),
      .rst         (rst),
      .load_start  (load_start),
      .wr_valid    (wr_valid),
      .wr_data     (wr_data),
      .wr_last     (wr_last),
      .wr_ready    (wr_ready),
      .run_start   (run_start),
      .loop_en     (loop_en),
      .stall       (stall),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .cpu_rst     (cpu_rst),
      .done        (done),
      .prog_len    (prog_len),
      .issue_count (issue_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_check();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_instr_out", instr_out, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_cpu_rst", cpu_rst, 1);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_prog_len", prog_len, 0);
      chk("rst_issue_count", issue_count, 0);
      prog.delete();
   endtask

   // Offers every word of ld_words back to back; the model keeps what the buffer should accept.
   task automatic load_prog(input bit use_last, input bit also_run);
      bit full = 1'b0;
      load_start = 1'b1;
      run_start  = also_run;
      step();
      load_start = 1'b0;
      run_start  = 1'b0;
      chk("load_ready", wr_ready, 1);
      chk("load_cpu_rst", cpu_rst, 1);
      chk("load_prog_len0", prog_len, 0);
      chk("load_valid", instr_valid, 0);
      prog.delete();
      for (int i = 0; i < ld_words.size(); i++) begin
         chk("wr_ready", wr_ready, {31'd0, !full});
         wr_valid = 1'b1;
         wr_data  = ld_words[i];
         wr_last  = use_last && (i == ld_words.size() - 1);
         step();
         if (!full) begin
            prog.push_back(ld_words[i]);
            if (wr_last || prog.size() == DEPTH) full = 1'b1;
         end
         chk("load_cpu_rst_hold", cpu_rst, 1);
      end
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      step();
      chk("wr_ready_after", wr_ready, 0);
      chk("prog_len", prog_len, prog.size());
      chk("idle_cpu_rst", cpu_rst, 1);
   endtask

   // Replays the model program cycle by cycle and compares every output.
   task automatic run_prog(input bit lp, input int ncyc, input int stall_pct, input logic [31:0] smask);
      int idx = 0;
      int cnt = 0;
      bit halted = 1'b0;
      logic [IW-1:0] eo;
      bit ev;
      bit ed;
      loop_en   = lp;
      run_start = 1'b1;
      step();
      run_start = 1'b0;
      chk("entry_cpu_rst", cpu_rst, 0);
      chk("entry_valid", instr_valid, 0);
      chk("entry_count", issue_count, 0);
      chk("entry_done", done, 0);
      for (int c = 0; c < ncyc; c++) begin
         stall = ((c < 32) && smask[c]) || (int'($urandom_range(99)) < stall_pct);
         step();
         ed = halted;
         if (halted || stall) begin
            eo = '0;
            ev = 1'b0;
         end else begin
            eo = prog[idx];
            ev = 1'b1;
            cnt = (cnt < 255) ? cnt + 1 : 255;
            if (idx == prog.size() - 1) begin
               idx = 0;
               if (!lp) halted = 1'b1;
            end else begin
               idx++;
            end
         end
         chk("run_instr_out", instr_out, eo);
         chk("run_valid", instr_valid, ev);
         chk("run_done", done, ed);
         chk("run_count", issue_count, cnt);
         chk("run_cpu_rst", cpu_rst, 0);
      end
      stall = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load_start = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
      run_start = 1'b0; loop_en = 1'b0; stall = 1'b0;
      step();
      rst_check();

      // Empty buffer: run_start must be ignored.
      run_start = 1'b1;
      step();
      run_start = 1'b0;
      step();
      chk("empty_run_cpu_rst", cpu_rst, 1);
      chk("empty_run_valid", instr_valid, 0);
      chk("empty_run_done", done, 0);

      ld_words = '{6'h01, 6'h12, 6'h3F};
      load_prog(1'b1, 1'b0);
      run_prog(1'b0, 6, 0, 32'h0);
      chk("halt_issue_count", issue_count, 3);
      chk("halt_done", done, 1);
      run_prog(1'b0, 7, 0, 32'h6);
      run_prog(1'b1, 8, 0, 32'h0);

      // Reset mid-run clears the program length, so run_start stays ignored.
      rst_check();
      run_start = 1'b1;
      step();
      step();
      run_start = 1'b0;
      step();
      chk("post_rst_run_cpu_rst", cpu_rst, 1);
      chk("post_rst_run_valid", instr_valid, 0);

      ld_words.delete();
      for (int i = 0; i < 17; i++) ld_words.push_back(IW'($urandom));
      load_prog(1'b0, 1'b0);
      run_prog(1'b0, 20, 0, 32'h0);

      // load_start and run_start together from HALT: load wins.
      ld_words = '{6'h2A, 6'h15};
      load_prog(1'b1, 1'b1);
      run_prog(1'b1, 270, 0, 32'h0);
      rst_check();

      for (int t = 0; t < 6; t++) begin
         int len;
         bit lp;
         len = int'($urandom_range(16, 1));
         lp  = 1'($urandom_range(1));
         ld_words.delete();
         for (int i = 0; i < len; i++) ld_words.push_back(IW'($urandom));
         load_prog(1'b1, 1'($urandom_range(1)));
         run_prog(lp, 2 * len + 6, 25, 32'h0);
         if (lp) rst_check();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
